// File: rtl/spi_flash_read_cache_pkg.sv
// Shared types for the SPI flash read cache: fill FSM encoding and data width.
package spi_flash_read_cache_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_GAP  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/spi_flash_read_cache_if.sv
// CPU-side and flash-side signals of the read cache; slave = cache, master = its environment.
interface spi_flash_read_cache_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] word_address;
  logic              rstrb;
  logic [31:0]       rdata;
  logic              rbusy;
  logic              invalidate;
  logic [ADDR_W-1:0] flash_word_address;
  logic              flash_rstrb;
  logic [31:0]       flash_rdata;
  logic              flash_rbusy;

  modport slave (
    input  word_address, rstrb, invalidate, flash_rdata, flash_rbusy,
    output rdata, rbusy, flash_word_address, flash_rstrb
  );

  modport master (
    output word_address, rstrb, invalidate, flash_rdata, flash_rbusy,
    input  rdata, rbusy, flash_word_address, flash_rstrb
  );
endinterface

// File: rtl/spi_flash_read_cache_tag_store.sv
// Valid/tag registers for the direct-mapped cache: combinational hit, one write port,
// single-cycle clear of all valid bits (clear wins over a same-cycle write).
module cache_tag_store #(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [IDX_W-1:0] lk_idx_i,
  input  logic [TAG_W-1:0] lk_tag_i,
  output logic             hit_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic             wr_valid_i
);

  logic [LINES-1:0]            valid_q;
  logic [LINES-1:0][TAG_W-1:0] tag_q;

  assign hit_o = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (wr_en_i) begin
        tag_q[wr_idx_i]   <= wr_tag_i;
        valid_q[wr_idx_i] <= wr_valid_i;
      end
      if (clear_i) valid_q <= '0;
    end
  end

endmodule

// File: rtl/spi_flash_read_cache.sv
// Direct-mapped read-only line cache in front of the memory-mapped SPI flash reader.
// Misses fill the whole line word 0 upward with single-word flash reads.
module spi_flash_read_cache
  import spi_flash_read_cache_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_flash_read_cache_if.slave bus
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int AW    = OFF_W + IDX_W;
  localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int DEPTH = LINES * LINE_WORDS;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LINE_WORDS - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    fill_cnt_q;
  logic [CNT_W-1:0]    off_q;
  logic [ADDR_W-1:0]   base_q;
  logic                inv_seen_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rbusy_q;
  logic [ADDR_W-1:0]   faddr_q;
  logic                fstrb_q;
  logic [DATA_W-1:0]   data_q [DEPTH];

  logic                tag_hit;
  logic                accept;
  logic                is_hit;
  logic                fill_we;
  logic [AW-1:0]       fill_word;
  logic [CNT_W-1:0]    next_cnt;

  assign accept    = (state_q == ST_IDLE) && bus.rstrb;
  // A same-cycle invalidate forces the lookup to miss.
  assign is_hit    = accept && tag_hit && !bus.invalidate;
  assign fill_we   = (state_q == ST_WAIT) && !bus.flash_rbusy;
  assign fill_word = base_q[AW-1:0] | AW'(fill_cnt_q);
  assign next_cnt  = fill_cnt_q + 1'b1;

  cache_tag_store #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_tags (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (bus.invalidate),
    .lk_idx_i   (bus.word_address[OFF_W +: IDX_W]),
    .lk_tag_i   (bus.word_address[AW +: TAG_W]),
    .hit_o      (tag_hit),
    .wr_en_i    (state_q == ST_DONE),
    .wr_idx_i   (base_q[OFF_W +: IDX_W]),
    .wr_tag_i   (base_q[AW +: TAG_W]),
    .wr_valid_i (!(inv_seen_q || bus.invalidate))
  );

  // Data array kept free of reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && fill_we) data_q[fill_word] <= bus.flash_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fill_cnt_q <= '0;
      off_q      <= '0;
      base_q     <= '0;
      inv_seen_q <= 1'b0;
      rdata_q    <= '0;
      rbusy_q    <= 1'b0;
      faddr_q    <= '0;
      fstrb_q    <= 1'b0;
    end else begin
      if (bus.invalidate) inv_seen_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (is_hit) begin
            rdata_q <= data_q[bus.word_address[AW-1:0]];
          end else if (accept) begin
            base_q     <= bus.word_address & ~OFF_MASK;
            off_q      <= CNT_W'(bus.word_address & OFF_MASK);
            fill_cnt_q <= '0;
            inv_seen_q <= 1'b0;
            rbusy_q    <= 1'b1;
            faddr_q    <= bus.word_address & ~OFF_MASK;
            fstrb_q    <= 1'b1;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          fstrb_q <= 1'b0;
          state_q <= ST_GAP;
        end
        ST_GAP: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (fill_we) begin
            if (fill_cnt_q == off_q) rdata_q <= bus.flash_rdata;
            if (fill_cnt_q == LAST_CNT) begin
              state_q <= ST_DONE;
            end else begin
              fill_cnt_q <= next_cnt;
              faddr_q    <= base_q | ADDR_W'(next_cnt);
              fstrb_q    <= 1'b1;
              state_q    <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          rbusy_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rdata              = rdata_q;
  assign bus.rbusy              = rbusy_q;
  assign bus.flash_word_address = faddr_q;
  assign bus.flash_rstrb        = fstrb_q;

endmodule
